// File: rtl/spi_flash_pkg.sv
// Shared constants, state encoding and helpers for the SPI flash read controller.
// Imported by the controller and its testbench.
package spi_flash_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam int         SPI_ADDR_BITS = 24;
  localparam int         CMD_BITS      = 8 + SPI_ADDR_BITS;
  localparam int         XFER_BITS     = 64;
  localparam int         DATA_BITS     = XFER_BITS - CMD_BITS;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RECV
  } state_e;

  // Bytes arrive lowest address first; the first one lands in the top of the
  // shift register, so it has to be swapped down into the low byte lane.
  function automatic logic [31:0] le_word(input logic [31:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

endpackage

// File: rtl/spi_flash_reader_if.sv
// Processor-side read port of the SPI flash controller: strobe, address, data, busy.
// The bus decoder drives the master modport; the controller uses the slave modport.
interface spi_flash_reader_if #(
  parameter int WORD_ADDR_WIDTH = 20
);

  logic                       rstrb;
  logic [WORD_ADDR_WIDTH-1:0] word_address;
  logic [31:0]                rdata;
  logic                       rbusy;

  modport master (
    output rstrb,
    output word_address,
    input  rdata,
    input  rbusy
  );

  modport slave (
    input  rstrb,
    input  word_address,
    output rdata,
    output rbusy
  );

endinterface

// File: rtl/spi_sck_gen.sv
// SCK divider: while run_i is high, SCK toggles every CLK_DIV clk cycles starting low.
// rise_en_o / fall_en_o flag the clk edge on which SCK goes high / low.
module spi_sck_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic sck_o,
  output logic rise_en_o,
  output logic fall_en_o
);

  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             sck_q;
  logic             phase_end;

  assign phase_end = run_i && (cnt_q == CNT_LAST);
  assign rise_en_o = phase_end && !sck_q;
  assign fall_en_o = phase_end && sck_q;
  assign sck_o     = sck_q;

  // NOTE: sequential state is only ever assigned with <= so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (!run_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (phase_end) begin
      cnt_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// Memory-mapped read-only window onto an SPI flash: each read strobe issues one
// READ (0x03) command and returns the 4 addressed bytes as a little-endian word.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV         = 1,
  parameter int WORD_ADDR_WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  spi_flash_reader_if.slave        bus,
  output logic                     spi_cs_n,
  output logic                     spi_clk,
  output logic                     spi_mosi,
  input  logic                     spi_miso
);

  localparam int BIT_CNT_W = $clog2(XFER_BITS);

  localparam logic [BIT_CNT_W-1:0] LAST_CMD_BIT  = BIT_CNT_W'(CMD_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_XFER_BIT = BIT_CNT_W'(XFER_BITS - 1);

  state_e                 state_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [CMD_BITS-2:0]    tx_shift_q;
  logic [DATA_BITS-1:0]   rx_shift_q;
  logic                   cs_n_q;
  logic                   mosi_q;
  logic                   rbusy_q;
  logic [31:0]            rdata_q;

  logic                     run;
  logic                     rise_en;
  logic                     fall_en;
  logic [SPI_ADDR_BITS-1:0] byte_addr;
  logic [CMD_BITS-1:0]      tx_word;

  assign byte_addr = SPI_ADDR_BITS'({bus.word_address, 2'b00});
  assign tx_word   = {SPI_CMD_READ, byte_addr};
  assign run       = (state_q != IDLE);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk       (clk),
    .reset     (reset),
    .run_i     (run),
    .sck_o     (spi_clk),
    .rise_en_o (rise_en),
    .fall_en_o (fall_en)
  );

  // NOTE: rdata sits on the async reset with everything else, so an aborted
  // transfer can never leave a half-assembled word visible on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rbusy_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.rstrb) begin
            mosi_q     <= tx_word[CMD_BITS-1];
            tx_shift_q <= tx_word[CMD_BITS-2:0];
            bit_cnt_q  <= '0;
            cs_n_q     <= 1'b0;
            rbusy_q    <= 1'b1;
            state_q    <= SEND;
          end
        end

        SEND: begin
          if (fall_en) begin
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            tx_shift_q <= {tx_shift_q[CMD_BITS-3:0], 1'b0};
            if (bit_cnt_q == LAST_CMD_BIT) begin
              mosi_q  <= 1'b0;
              state_q <= RECV;
            end else begin
              mosi_q <= tx_shift_q[CMD_BITS-2];
            end
          end
        end

        RECV: begin
          if (rise_en) begin
            rx_shift_q <= {rx_shift_q[DATA_BITS-2:0], spi_miso};
          end
          // The last falling edge closes the frame: the counter wraps to zero
          // and CS is released in the same cycle the word becomes visible.
          if (fall_en) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_XFER_BIT) begin
              cs_n_q  <= 1'b1;
              rbusy_q <= 1'b0;
              rdata_q <= le_word(rx_shift_q);
              state_q <= IDLE;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = mosi_q;
  assign bus.rbusy = rbusy_q;
  assign bus.rdata = rdata_q;

endmodule
